// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Truth tables are indexed by {a,b}.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      CHECK,
      DONE
   } state_t;

   localparam int VEC_W = 2;
   localparam int CNT_W = 4;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   localparam logic [VEC_W-1:0] VEC_LAST = 2'd3;

   function automatic logic tt_bit(
      input logic [3:0]       tt,
      input logic [VEC_W-1:0] vec
   );
      return tt[vec];
   endfunction

endpackage

// File: rtl/gate_bist_settle_timer.sv
// Settle counter: cleared while not applying a vector, counts up while
// applying, flags the last settle cycle.
import gate_bist_pkg::*;

module bist_settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/gate_bist.sv
// On-chip exhaustive test of a 2-input gate: drives 00..11, samples y_i
// after a settle time, and keeps pass plus the first failing vector.
import gate_bist_pkg::*;

module gate_bist #(
   parameter logic [3:0] TRUTH  = TT_XNOR,
   parameter int         SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   input  logic       y_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:0] fail_vec,
   output logic       fail_got
);

   state_t           state;
   state_t           nxt;
   logic [VEC_W-1:0] vec;
   logic             fail;
   logic             tmr_load;
   logic             tmr_en;
   logic             tc;
   logic             mismatch;
   logic             last_vec;

   bist_settle_timer #(
      .SETTLE(SETTLE)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .en   (tmr_en),
      .tc   (tc)
   );

   assign mismatch = (y_i != tt_bit(TRUTH, vec));
   assign last_vec = (vec == VEC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (start) nxt = APPLY;
         APPLY: if (tc) nxt = CHECK;
         CHECK: nxt = last_vec ? DONE : APPLY;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      tmr_load = 1'b1;
      tmr_en   = 1'b0;
      unique case (state)
         APPLY: begin
            busy     = 1'b1;
            tmr_load = 1'b0;
            tmr_en   = 1'b1;
         end
         CHECK: busy = 1'b1;
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec      <= '0;
         fail     <= 1'b0;
         pass     <= 1'b0;
         fail_vec <= '0;
         fail_got <= 1'b0;
         a_o      <= 1'b0;
         b_o      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  vec      <= '0;
                  fail     <= 1'b0;
                  pass     <= 1'b0;
                  fail_vec <= '0;
                  fail_got <= 1'b0;
                  a_o      <= 1'b0;
                  b_o      <= 1'b0;
               end
            end
            CHECK: begin
               if (mismatch && !fail) begin
                  fail     <= 1'b1;
                  fail_vec <= vec;
                  fail_got <= y_i;
               end
               // pass is written on the way into DONE so it is
               // already valid during the done pulse
               if (last_vec) begin
                  pass <= ~(fail | mismatch);
                  a_o  <= 1'b0;
                  b_o  <= 1'b0;
               end else begin
                  vec        <= vec + 1'b1;
                  {a_o, b_o} <= vec + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: three instances (xnor/S1, xor/S1,
// xnor/S3) each testing a modelled gate described by a 4-bit table.
module tb_gate_bist;

   logic       clk;
   logic       rst;
   logic       start    [3];
   logic       a_o      [3];
   logic       b_o      [3];
   logic       y        [3];
   logic       busy     [3];
   logic       done     [3];
   logic       pass     [3];
   logic [1:0] fail_vec [3];
   logic       fail_got [3];
   logic [3:0] gtab     [3];

   int tests_run;
   int tests_failed;

   localparam logic [3:0] XNOR = 4'b1001;
   localparam logic [3:0] XOR  = 4'b0110;
   localparam logic [3:0] INST_TT [3] = '{XNOR, XOR, XNOR};
   localparam int         INST_S  [3] = '{1, 1, 3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign y[0] = gtab[0][{a_o[0], b_o[0]}];
   assign y[1] = gtab[1][{a_o[1], b_o[1]}];
   assign y[2] = gtab[2][{a_o[2], b_o[2]}];

   gate_bist #(.TRUTH(4'b1001), .SETTLE(1)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .a_o(a_o[0]), .b_o(b_o[0]),
      .y_i(y[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .fail_vec(fail_vec[0]), .fail_got(fail_got[0]));

   gate_bist #(.TRUTH(4'b0110), .SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .a_o(a_o[1]), .b_o(b_o[1]),
      .y_i(y[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .fail_vec(fail_vec[1]), .fail_got(fail_got[1]));

   gate_bist #(.TRUTH(4'b1001), .SETTLE(3)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .a_o(a_o[2]), .b_o(b_o[2]),
      .y_i(y[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .fail_vec(fail_vec[2]), .fail_got(fail_got[2]));

   // Reference: first index where the gate disagrees with the table
   function automatic void model(
      input  logic [3:0] truth,
      input  logic [3:0] gate,
      output logic       p,
      output logic [1:0] fv,
      output logic       fg
   );
      p  = 1'b1;
      fv = 2'd0;
      fg = 1'b0;
      for (int v = 0; v < 4; v++) begin
         if (p && gate[v] != truth[v]) begin
            p  = 1'b0;
            fv = 2'(v);
            fg = gate[v];
         end
      end
   endfunction

   // Runs one start pulse on instance i and records what it saw.
   // Cycle c is the cycle following edge E0+c-1 (E0 = start edge).
   task automatic obs_run(
      input  int         i,
      input  int         extra,
      output int         dcyc,
      output logic [7:0] abf,
      output logic [7:0] abl,
      output int         busy_bad,
      output logic       p,
      output logic [1:0] fv,
      output logic       fg
   );
      int s;
      s        = INST_S[i];
      dcyc     = -1;
      busy_bad = 0;
      abf      = 8'h00;
      abl      = 8'h00;
      p        = 1'bx;
      fv       = 2'bxx;
      fg       = 1'bx;
      @(negedge clk);
      start[i] = 1'b1;
      for (int c = 1; c <= 200 && dcyc < 0; c++) begin
         @(negedge clk);
         start[i] = (c == extra);
         for (int k = 0; k < 4; k++) begin
            if (c == k * (s + 1) + 1) abf[2*k +: 2] = {a_o[i], b_o[i]};
            if (c == (k + 1) * (s + 1)) abl[2*k +: 2] = {a_o[i], b_o[i]};
         end
         if (done[i] === 1'b1) begin
            dcyc = c;
            p    = pass[i];
            fv   = fail_vec[i];
            fg   = fail_got[i];
            if (busy[i] !== 1'b0) busy_bad++;
         end else if (busy[i] !== 1'b1) begin
            busy_bad++;
         end
      end
      start[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({a_o[0], b_o[0], busy[0], done[0]} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctl got %b exp 0000",
                  {a_o[0], b_o[0], busy[0], done[0]});
      end
      tests_run++;
      if ({pass[0], fail_vec[0], fail_got[0]} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_res got %b exp 0000",
                  {pass[0], fail_vec[0], fail_got[0]});
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (busy[2] !== 1'b0 || pass[2] !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_u2 got busy=%b pass=%b exp 0 0",
                  busy[2], pass[2]);
      end
   endtask

   task automatic test_good_xnor;
      int d, bb;
      logic [7:0] f, l;
      logic p, g;
      logic [1:0] v;
      gtab[0] = XNOR;
      obs_run(0, -1, d, f, l, bb, p, v, g);
      tests_run++;
      if (d !== 9) begin
         tests_failed++;
         $display("FAIL good_done_cycle got %0d exp 9", d);
      end
      tests_run++;
      if (f !== 8'he4 || l !== 8'he4) begin
         tests_failed++;
         $display("FAIL good_vectors got %h/%h exp e4/e4", f, l);
      end
      tests_run++;
      if (bb !== 0) begin
         tests_failed++;
         $display("FAIL good_busy got %0d bad cycles exp 0", bb);
      end
      tests_run++;
      if ({p, v, g} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL good_result got %b exp 1000", {p, v, g});
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (pass[0] !== 1'b1 || done[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL good_hold got pass=%b done=%b exp 1 0",
                  pass[0], done[0]);
      end
   endtask

   task automatic test_xor_truth;
      int d, bb;
      logic [7:0] f, l;
      logic p, g;
      logic [1:0] v;
      gtab[1] = XNOR;
      obs_run(1, -1, d, f, l, bb, p, v, g);
      tests_run++;
      if ({p, v, g} !== 4'b0001) begin
         tests_failed++;
         $display("FAIL xor_result got %b exp 0001", {p, v, g});
      end
      tests_run++;
      if (d !== 9) begin
         tests_failed++;
         $display("FAIL xor_done_cycle got %0d exp 9", d);
      end
   endtask

   task automatic test_stuck1;
      int d, bb;
      logic [7:0] f, l;
      logic p, g;
      logic [1:0] v;
      gtab[0] = 4'b1111;
      obs_run(0, -1, d, f, l, bb, p, v, g);
      tests_run++;
      if ({p, v, g} !== 4'b0011) begin
         tests_failed++;
         $display("FAIL stuck1_result got %b exp 0011", {p, v, g});
      end
      tests_run++;
      if (d !== 9 || f !== 8'he4) begin
         tests_failed++;
         $display("FAIL stuck1_run got done=%0d vec=%h exp 9 e4", d, f);
      end
   endtask

   task automatic test_settle3;
      int d, bb;
      logic [7:0] f, l;
      logic p, g;
      logic [1:0] v;
      gtab[2] = XNOR;
      obs_run(2, 5, d, f, l, bb, p, v, g);
      tests_run++;
      if (d !== 17) begin
         tests_failed++;
         $display("FAIL s3_done_cycle got %0d exp 17", d);
      end
      tests_run++;
      if (f !== 8'he4 || l !== 8'he4 || bb !== 0) begin
         tests_failed++;
         $display("FAIL s3_seq got %h/%h busybad=%0d exp e4/e4 0",
                  f, l, bb);
      end
      tests_run++;
      if ({p, v, g} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL s3_result got %b exp 1000", {p, v, g});
      end
   endtask

   task automatic test_mid_reset;
      int d, bb;
      logic [7:0] f, l;
      logic p, g;
      logic [1:0] v;
      gtab[0] = XNOR;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++;
      if ({a_o[0], b_o[0], busy[0]} !== 3'b101) begin
         tests_failed++;
         $display("FAIL mr_pre got %b exp 101", {a_o[0], b_o[0], busy[0]});
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({a_o[0], b_o[0], busy[0], pass[0]} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL mr_async got %b exp 0000",
                  {a_o[0], b_o[0], busy[0], pass[0]});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      obs_run(0, -1, d, f, l, bb, p, v, g);
      tests_run++;
      if (d !== 9 || f !== 8'he4 || {p, v, g} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL mr_rerun got done=%0d vec=%h res=%b exp 9 e4 1000",
                  d, f, {p, v, g});
      end
   endtask

   task automatic test_back_to_back;
      int dq[$];
      logic p9, p10, p11, b10;
      gtab[0] = XNOR;
      p9 = 1'bx; p10 = 1'bx; p11 = 1'bx; b10 = 1'bx;
      @(negedge clk);
      start[0] = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         @(negedge clk);
         if (done[0] === 1'b1) dq.push_back(c);
         if (c == 9) p9 = pass[0];
         if (c == 10) begin p10 = pass[0]; b10 = busy[0]; end
         if (c == 11) p11 = pass[0];
      end
      start[0] = 1'b0;
      repeat (12) @(negedge clk);
      tests_run++;
      if (dq.size() != 2 || dq[0] != 9 || dq[1] != 19) begin
         tests_failed++;
         $display("FAIL b2b_done got n=%0d first=%0d exp 2 runs at 9,19",
                  dq.size(), (dq.size() > 0) ? dq[0] : -1);
      end
      tests_run++;
      if ({p9, p10, b10, p11} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL b2b_clear got %b exp 1100", {p9, p10, b10, p11});
      end
   endtask

   task automatic test_random;
      int d, bb, i;
      logic [7:0] f, l;
      logic p, g, ep, eg;
      logic [1:0] v, ev;
      for (int n = 0; n < 16; n++) begin
         i       = int'($urandom_range(2, 0));
         gtab[i] = 4'($urandom);
         model(INST_TT[i], gtab[i], ep, ev, eg);
         obs_run(i, -1, d, f, l, bb, p, v, g);
         tests_run++;
         if ({p, v, g} !== {ep, ev, eg}) begin
            tests_failed++;
            $display("FAIL rand_result u%0d tab=%b got %b exp %b",
                     i, gtab[i], {p, v, g}, {ep, ev, eg});
         end
         tests_run++;
         if (d !== 4 * (INST_S[i] + 1) + 1 || bb !== 0) begin
            tests_failed++;
            $display("FAIL rand_timing u%0d got done=%0d busybad=%0d exp %0d 0",
                     i, d, bb, 4 * (INST_S[i] + 1) + 1);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      gtab[0] = XNOR;
      gtab[1] = XNOR;
      gtab[2] = XNOR;
      test_reset();
      test_good_xnor();
      test_xor_truth();
      test_stuck1();
      test_settle3();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
